// File: rtl/int_arbiter_if.sv
// Signal bundle between the interrupt arbiter and its environment:
// peripheral interrupt lines, the CLINT handshake and the register bus.
interface int_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int INT_W   = 8
);
  logic [NUM_SRC-1:0] irq_i;
  logic               clint_busy_i;
  logic               we_i;
  logic [3:0]         addr_i;
  logic [31:0]        wdata_i;
  logic [31:0]        rdata_o;
  logic [INT_W-1:0]   int_flag_o;
  logic               int_active_o;

  modport master (
    output irq_i, clint_busy_i, we_i, addr_i, wdata_i,
    input  rdata_o, int_flag_o, int_active_o
  );

  modport slave (
    input  irq_i, clint_busy_i, we_i, addr_i, wdata_i,
    output rdata_o, int_flag_o, int_active_o
  );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt source arbiter: edge-latched pending bits, enable mask, fixed
// lowest-index-first priority and a claim/complete service handshake.
module int_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int INT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  int_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam logic [3:0] A_ENABLE   = 4'h0;
  localparam logic [3:0] A_PENDING  = 4'h4;
  localparam logic [3:0] A_CLAIM    = 4'h8;
  localparam logic [3:0] A_COMPLETE = 4'hC;

  logic [1:0]         state_reg, state_next;
  logic [NUM_SRC-1:0] enable_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] irq_q_reg;
  logic [INT_W-1:0]   claim_reg, claim_next;
  logic [INT_W-1:0]   flag_reg, flag_next;
  logic [31:0]        rdata_reg, rdata_next;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] sw_clr;
  logic [NUM_SRC-1:0] acc_clr;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] claim_oh;
  logic [INT_W-1:0]   low_code;
  logic               wr_enable, wr_pending, wr_complete;
  logic               accept;

  assign wr_enable   = bus.we_i && (bus.addr_i == A_ENABLE);
  assign wr_pending  = bus.we_i && (bus.addr_i == A_PENDING);
  assign wr_complete = bus.we_i && (bus.addr_i == A_COMPLETE);

  assign rise    = bus.irq_i & ~irq_q_reg;
  assign cand    = pending_reg & enable_reg;
  assign accept  = (state_reg == S_REQ) && bus.clint_busy_i;
  assign sw_clr  = wr_pending ? bus.wdata_i[NUM_SRC-1:0] : '0;
  assign acc_clr = accept ? claim_oh : '0;

  // Per-source bookkeeping; a new edge beats any clear in the same cycle.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign claim_oh[gi]     = (claim_reg == INT_W'(gi + 1));
      assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~sw_clr[gi] & ~acc_clr[gi]);
    end
  endgenerate

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    low_code = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        low_code = INT_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    claim_next = claim_reg;
    flag_next  = '0;
    case (state_reg)
      S_IDLE: begin
        if (|cand) begin
          state_next = S_REQ;
          claim_next = low_code;
        end
      end
      S_REQ: begin
        if (bus.clint_busy_i) begin
          state_next = S_SERVICE;
        end else if (~|(claim_oh & enable_reg & pending_reg)) begin
          // Request withdrawn by masking or software clear before acceptance.
          state_next = S_IDLE;
          claim_next = '0;
        end else begin
          flag_next = claim_reg;
        end
      end
      S_SERVICE: begin
        if (wr_complete && (bus.wdata_i[INT_W-1:0] == claim_reg)) begin
          state_next = S_IDLE;
          claim_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        claim_next = '0;
      end
    endcase
  end

  always_comb begin
    rdata_next = '0;
    case (bus.addr_i)
      A_ENABLE:  rdata_next[NUM_SRC-1:0] = enable_reg;
      A_PENDING: rdata_next[NUM_SRC-1:0] = pending_reg;
      A_CLAIM: begin
        if (state_reg == S_SERVICE) begin
          rdata_next[INT_W-1:0] = claim_reg;
        end
      end
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      enable_reg  <= '0;
      pending_reg <= '0;
      irq_q_reg   <= '0;
      claim_reg   <= '0;
      flag_reg    <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      irq_q_reg   <= bus.irq_i;
      claim_reg   <= claim_next;
      flag_reg    <= flag_next;
      rdata_reg   <= rdata_next;
      if (wr_enable) begin
        enable_reg <= bus.wdata_i[NUM_SRC-1:0];
      end
    end
  end

  assign bus.rdata_o      = rdata_reg;
  assign bus.int_flag_o   = flag_reg;
  assign bus.int_active_o = (state_reg == S_SERVICE);

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenario tasks plus a randomized run checked
// against a behavioural model of the arbiter's request/service rules.
module tb_int_arbiter;

  localparam logic [3:0] A_EN = 4'h0;
  localparam logic [3:0] A_PD = 4'h4;
  localparam logic [3:0] A_CL = 4'h8;
  localparam logic [3:0] A_CP = 4'hC;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int_arbiter_if #(.NUM_SRC(4), .INT_W(8)) bus ();

  int_arbiter #(.NUM_SRC(4), .INT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = nothing presented, 1 = offering a code, 2 = being serviced.
  int          m_phase;
  logic [3:0]  m_prev, m_pend, m_en;
  logic [7:0]  m_code, m_flag;
  logic [31:0] m_rdata;

  task automatic tick();
    logic [3:0]  rise, clr;
    logic [31:0] rd;
    logic [7:0]  code, flag;
    int          ph, lo, idx;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_prev = 0; m_pend = 0; m_en = 0;
      m_code = 0; m_flag = 0; m_rdata = 0;
    end else begin
      rise = bus.irq_i & ~m_prev;
      rd = 32'd0;
      if (bus.addr_i == A_EN) rd = {28'd0, m_en};
      else if (bus.addr_i == A_PD) rd = {28'd0, m_pend};
      else if (bus.addr_i == A_CL && m_phase == 2) rd = {24'd0, m_code};
      clr  = (bus.we_i && bus.addr_i == A_PD) ? bus.wdata_i[3:0] : 4'd0;
      ph   = m_phase;
      code = m_code;
      flag = 8'd0;
      idx  = int'(m_code) - 1;
      if (m_phase == 0) begin
        lo = -1;
        for (int k = 3; k >= 0; k--) if (m_pend[k] && m_en[k]) lo = k;
        if (lo >= 0) begin ph = 1; code = 8'(lo + 1); end
      end else if (m_phase == 1) begin
        if (bus.clint_busy_i) begin
          ph = 2;
          if (idx >= 0 && idx < 4) clr[idx] = 1'b1;
        end else if (idx < 0 || idx > 3 || !(m_en[idx] && m_pend[idx])) begin
          ph = 0; code = 0;
        end else begin
          flag = m_code;
        end
      end else begin
        if (bus.we_i && bus.addr_i == A_CP && bus.wdata_i[7:0] == m_code) begin
          ph = 0; code = 0;
        end
      end
      m_pend = (m_pend & ~clr) | rise;
      if (bus.we_i && bus.addr_i == A_EN) m_en = bus.wdata_i[3:0];
      m_prev = bus.irq_i; m_phase = ph; m_code = code; m_flag = flag; m_rdata = rd;
    end
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.addr_i = a; bus.wdata_i = d; bus.we_i = 1'b1;
    tick();
    bus.we_i = 1'b0; bus.wdata_i = 32'd0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
    bus.addr_i = a;
    tick();
    v = bus.rdata_o;
  endtask

  task automatic pulse(input logic [3:0] m);
    bus.irq_i = bus.irq_i | m;
    tick();
    bus.irq_i = bus.irq_i & ~m;
  endtask

  task automatic accept();
    bus.clint_busy_i = 1'b1;
    tick();
    bus.clint_busy_i = 1'b0;
  endtask

  task automatic wait_flag(input int budget, output logic [7:0] seen);
    int i = 0;
    while (bus.int_flag_o == 8'd0 && i < budget) begin tick(); i++; end
    seen = bus.int_flag_o;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; tick(); tick();
    total++; if (bus.int_flag_o !== 8'd0) begin bad++; $display("FAIL reset_flag: got %h want 00", bus.int_flag_o); end
    total++; if (bus.int_active_o !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", bus.int_active_o); end
    total++; if (bus.rdata_o !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
    rst = 1'b0;
    read_reg(A_EN, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_enable: got %h want 0", v); end
    read_reg(A_PD, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_pending: got %h want 0", v); end
  endtask

  task automatic test_single();
    logic [31:0] v;
    logic [7:0]  f;
    bus_write(A_EN, 32'hF);
    pulse(4'h4);
    read_reg(A_PD, v);
    total++; if (v !== 32'h4) begin bad++; $display("FAIL single_pending: got %h want 4", v); end
    wait_flag(2, f);
    total++; if (f !== 8'h03) begin bad++; $display("FAIL single_flag: got %h want 03", f); end
    accept();
    total++; if (bus.int_active_o !== 1'b1 || bus.int_flag_o !== 8'd0) begin
      bad++; $display("FAIL single_service: active=%b flag=%h want 1/00", bus.int_active_o, bus.int_flag_o); end
    read_reg(A_PD, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL single_pend_clr: got %h want 0", v); end
    read_reg(A_CL, v);
    total++; if (v !== 32'h3) begin bad++; $display("FAIL single_claim: got %h want 3", v); end
    bus_write(A_CP, 32'h3);
    total++; if (bus.int_active_o !== 1'b0) begin bad++; $display("FAIL single_complete: active=%b want 0", bus.int_active_o); end
    repeat (3) tick();
    total++; if (bus.int_flag_o !== 8'd0) begin bad++; $display("FAIL single_idle_flag: got %h want 00", bus.int_flag_o); end
  endtask

  task automatic test_priority();
    logic [7:0] f;
    pulse(4'hA);
    wait_flag(4, f);
    total++; if (f !== 8'h02) begin bad++; $display("FAIL prio_first: got %h want 02", f); end
    accept();
    bus_write(A_CP, 32'h2);
    wait_flag(4, f);
    total++; if (f !== 8'h04) begin bad++; $display("FAIL prio_second: got %h want 04", f); end
    accept();
    bus_write(A_CP, 32'h4);
    total++; if (bus.int_active_o !== 1'b0) begin bad++; $display("FAIL prio_done: active=%b want 0", bus.int_active_o); end
  endtask

  task automatic test_masked();
    logic [31:0] v;
    logic [7:0]  f;
    bus_write(A_EN, 32'h0);
    pulse(4'h1);
    read_reg(A_PD, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL mask_pending: got %h want 1", v); end
    repeat (3) tick();
    total++; if (bus.int_flag_o !== 8'd0) begin bad++; $display("FAIL mask_flag: got %h want 00", bus.int_flag_o); end
    bus_write(A_EN, 32'h1);
    wait_flag(4, f);
    total++; if (f !== 8'h01) begin bad++; $display("FAIL unmask_flag: got %h want 01", f); end
  endtask

  task automatic test_req_drop();
    logic [31:0] v;
    bus_write(A_EN, 32'h0);
    tick();
    total++; if (bus.int_flag_o !== 8'd0 || bus.int_active_o !== 1'b0) begin
      bad++; $display("FAIL drop_idle: flag=%h active=%b want 00/0", bus.int_flag_o, bus.int_active_o); end
    read_reg(A_PD, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL drop_pending: got %h want 1", v); end
    bus_write(A_PD, 32'h1);
    read_reg(A_PD, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h want 0", v); end
  endtask

  task automatic test_complete();
    logic [31:0] v;
    logic [7:0]  f;
    bus_write(A_EN, 32'hF);
    pulse(4'h2);
    wait_flag(4, f);
    total++; if (f !== 8'h02) begin bad++; $display("FAIL cmp_flag: got %h want 02", f); end
    accept();
    bus_write(A_CP, 32'h3);
    total++; if (bus.int_active_o !== 1'b1) begin bad++; $display("FAIL cmp_mismatch: active=%b want 1", bus.int_active_o); end
    read_reg(A_CL, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL cmp_claim: got %h want 2", v); end
    bus_write(A_CP, 32'h2);
    total++; if (bus.int_active_o !== 1'b0) begin bad++; $display("FAIL cmp_match: active=%b want 0", bus.int_active_o); end
    bus.irq_i = 4'h2;
    bus_write(A_PD, 32'h2);
    bus.irq_i = 4'h0;
    read_reg(A_PD, v);
    total++; if (v[1] !== 1'b1) begin bad++; $display("FAIL set_wins: pending=%h want bit1 set", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [7:0]  f;
    wait_flag(4, f);
    accept();
    total++; if (bus.int_active_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre: active=%b want 1", bus.int_active_o); end
    rst = 1'b1; tick();
    total++; if (bus.int_flag_o !== 8'd0 || bus.int_active_o !== 1'b0 || bus.rdata_o !== 32'd0) begin
      bad++; $display("FAIL rstmid_out: flag=%h active=%b rdata=%h want 0", bus.int_flag_o, bus.int_active_o, bus.rdata_o); end
    rst = 1'b0;
    read_reg(A_EN, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rstmid_enable: got %h want 0", v); end
    read_reg(A_PD, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rstmid_pending: got %h want 0", v); end
    // Line held high across reset: once cleared, it must not re-request until it toggles.
    bus.irq_i = 4'h1;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick(); tick();
    bus_write(A_PD, 32'h1);
    tick();
    read_reg(A_PD, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL held_high: pending=%h want 0", v); end
    bus.irq_i = 4'h0; tick();
    bus.irq_i = 4'h1; tick();
    read_reg(A_PD, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL re_rise: pending=%h want 1", v); end
    bus.irq_i = 4'h0;
  endtask

  task automatic test_random();
    logic [3:0] a;
    rst = 1'b1; tick(); rst = 1'b0;
    bus_write(A_EN, 32'($urandom_range(1, 15)));
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) bus.irq_i = 4'($urandom);
      bus.clint_busy_i = ($urandom_range(0, 3) == 0);
      a = 4'($urandom_range(0, 3) << 2);
      bus.addr_i = a;
      bus.we_i   = ($urandom_range(0, 5) == 0);
      if (a == A_CP) bus.wdata_i = $urandom_range(0, 1) ? {24'd0, m_code} : 32'($urandom_range(0, 5));
      else if (a == A_EN) bus.wdata_i = 32'($urandom_range(0, 15));
      else bus.wdata_i = $urandom;
      tick();
      total++; if (bus.int_flag_o !== m_flag) begin bad++; $display("FAIL rnd_flag[%0d]: got %h want %h", n, bus.int_flag_o, m_flag); end
      total++; if (bus.int_active_o !== (m_phase == 2)) begin bad++; $display("FAIL rnd_active[%0d]: got %b want %b", n, bus.int_active_o, m_phase == 2); end
      total++; if (bus.rdata_o !== m_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, bus.rdata_o, m_rdata); end
    end
    bus.we_i = 1'b0; bus.clint_busy_i = 1'b0; bus.irq_i = 4'h0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.irq_i = '0; bus.clint_busy_i = 1'b0; bus.we_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0;
    m_phase = 0; m_prev = 0; m_pend = 0; m_en = 0; m_code = 0; m_flag = 0; m_rdata = 0;
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_req_drop();
    test_complete();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
